// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: requester and memory-pin bundle for mem_arbiter.
// slave = arbiter side, master = ICache/DCache/RAM side.
interface mem_arbiter_if #(
  parameter int ADDR_W = 32
);
  logic [7:0]        mem_din;
  logic [7:0]        mem_dout;
  logic [ADDR_W-1:0] mem_a;
  logic              mem_wr;

  logic              IC_sgn;
  logic [ADDR_W-1:0] IC_addr;
  logic              IC_done;
  logic [31:0]       IC_data;

  logic              DC_sgn;
  logic [ADDR_W-1:0] DC_addr;
  logic [31:0]       DC_val;
  logic [5:0]        DC_opcode;
  logic              DC_done;
  logic [31:0]       DC_data;

  modport slave (
    input  mem_din,
    output mem_dout,
    output mem_a,
    output mem_wr,
    input  IC_sgn,
    input  IC_addr,
    output IC_done,
    output IC_data,
    input  DC_sgn,
    input  DC_addr,
    input  DC_val,
    input  DC_opcode,
    output DC_done,
    output DC_data
  );

  modport master (
    output mem_din,
    input  mem_dout,
    input  mem_a,
    input  mem_wr,
    output IC_sgn,
    output IC_addr,
    input  IC_done,
    input  IC_data,
    output DC_sgn,
    output DC_addr,
    output DC_val,
    output DC_opcode,
    input  DC_done,
    input  DC_data
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the byte-wide RAM/IO port between ICache and DCache.
// Optional IO write back-pressure: define IO_BUFFER_FULL_EN.
module mem_arbiter #(
  parameter int         ADDR_W = 32,
  parameter logic [1:0] IO_HI  = 2'b11
) (
  input  logic clk,
  input  logic rst,
  input  logic rdy,
  input  logic io_buffer_full,
  input  logic jp_wrong,
  mem_arbiter_if.slave bus
);

  localparam logic [5:0] OP_LB  = 6'd1;
  localparam logic [5:0] OP_LH  = 6'd2;
  localparam logic [5:0] OP_LW  = 6'd3;
  localparam logic [5:0] OP_LBU = 6'd4;
  localparam logic [5:0] OP_LHU = 6'd5;
  localparam logic [5:0] OP_SB  = 6'd6;
  localparam logic [5:0] OP_SH  = 6'd7;
  localparam logic [5:0] OP_SW  = 6'd8;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    WRITE,
    DONE
  } state_t;

  state_t            state_q, state_d;
  logic              last_dc_q, last_dc_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [1:0]        nm1_q, nm1_d;
  logic [5:0]        op_q, op_d;
  logic [31:0]       st_val_q, st_val_d;
  logic [1:0]        k_q, k_d;
  logic [1:0]        rcv_q, rcv_d;
  logic              v_q, v_d;
  logic [31:0]       buf_q, buf_d;
  logic [ADDR_W-1:0] mem_a_q, mem_a_d;
  logic [7:0]        mem_dout_q, mem_dout_d;
  logic              mem_wr_q, mem_wr_d;
  logic              ic_done_q, ic_done_d;
  logic              dc_done_q, dc_done_d;
  logic [31:0]       ic_data_q, ic_data_d;
  logic [31:0]       dc_data_q, dc_data_d;

  logic        dc_store;
  logic [1:0]  dc_nm1;
  logic        ic_el, dc_el;
  logic        acc, pick_dc, pick_ic;
  logic [31:0] asm_w, ext_w;
  logic [1:0]  k_nx;
  logic        io_block;

`ifdef IO_BUFFER_FULL_EN
  assign io_block = (state_q == WRITE)
                  && (mem_a_q[17:16] == IO_HI)
                  && io_buffer_full;
`else
  logic unused_io;
  assign unused_io = io_buffer_full;
  assign io_block  = 1'b0;
`endif

  assign bus.mem_a    = mem_a_q;
  assign bus.mem_dout = mem_dout_q;
  assign bus.mem_wr   = mem_wr_q & rdy & ~io_block;
  assign bus.IC_done  = ic_done_q;
  assign bus.IC_data  = ic_data_q;
  assign bus.DC_done  = dc_done_q;
  assign bus.DC_data  = dc_data_q;

  // Decode DC opcode into direction and last byte index.
  always_comb begin
    dc_store = 1'b0;
    dc_nm1   = 2'd3;
    unique case (1'b1)
      (bus.DC_opcode == OP_LB),
      (bus.DC_opcode == OP_LBU): dc_nm1 = 2'd0;
      (bus.DC_opcode == OP_LH),
      (bus.DC_opcode == OP_LHU): dc_nm1 = 2'd1;
      (bus.DC_opcode == OP_SB): begin
        dc_store = 1'b1;
        dc_nm1   = 2'd0;
      end
      (bus.DC_opcode == OP_SH): begin
        dc_store = 1'b1;
        dc_nm1   = 2'd1;
      end
      (bus.DC_opcode == OP_SW): dc_store = 1'b1;
      default: dc_nm1 = 2'd3;
    endcase
  end

  // Round-robin grant; the one just served sits out its DONE edge.
  always_comb begin
    ic_el   = bus.IC_sgn
            & ~((state_q == DONE) & ~last_dc_q);
    dc_el   = bus.DC_sgn
            & ~((state_q == DONE) & last_dc_q);
    acc     = rdy & ~jp_wrong
            & ((state_q == IDLE) | (state_q == DONE));
    pick_dc = acc & dc_el & (~ic_el | ~last_dc_q);
    pick_ic = acc & ic_el & ~pick_dc;
  end

  // Assemble the read word with the byte arriving this cycle.
  always_comb begin
    asm_w = buf_q;
    asm_w[{rcv_q, 3'b000} +: 8] = bus.mem_din;
  end

  // Sign or zero extend the assembled load.
  always_comb begin
    ext_w = asm_w;
    unique case (1'b1)
      (op_q == OP_LB):
        ext_w = {{24{asm_w[7]}}, asm_w[7:0]};
      (op_q == OP_LH):
        ext_w = {{16{asm_w[15]}}, asm_w[15:0]};
      (op_q == OP_LBU):
        ext_w = {24'd0, asm_w[7:0]};
      (op_q == OP_LHU):
        ext_w = {16'd0, asm_w[15:0]};
      default: ext_w = asm_w;
    endcase
  end

  assign k_nx = k_q + 2'd1;

  // Next state and registered outputs.
  always_comb begin
    state_d    = state_q;
    last_dc_d  = last_dc_q;
    addr_d     = addr_q;
    nm1_d      = nm1_q;
    op_d       = op_q;
    st_val_d   = st_val_q;
    k_d        = k_q;
    rcv_d      = rcv_q;
    v_d        = v_q;
    buf_d      = buf_q;
    mem_a_d    = mem_a_q;
    mem_dout_d = mem_dout_q;
    mem_wr_d   = mem_wr_q;
    ic_done_d  = ic_done_q;
    dc_done_d  = dc_done_q;
    ic_data_d  = ic_data_q;
    dc_data_d  = dc_data_q;
    if (rdy) begin
      unique case (state_q)
        IDLE, DONE: begin
          state_d   = IDLE;
          mem_wr_d  = 1'b0;
          ic_done_d = 1'b0;
          dc_done_d = 1'b0;
          if (pick_dc || pick_ic) begin
            last_dc_d = pick_dc;
            k_d       = 2'd0;
            rcv_d     = 2'd0;
            v_d       = 1'b0;
            buf_d     = 32'd0;
          end
          if (pick_dc) begin
            addr_d   = bus.DC_addr;
            mem_a_d  = bus.DC_addr;
            nm1_d    = dc_nm1;
            op_d     = bus.DC_opcode;
            st_val_d = bus.DC_val;
            if (dc_store) begin
              state_d    = WRITE;
              mem_wr_d   = 1'b1;
              mem_dout_d = bus.DC_val[7:0];
            end else begin
              state_d = READ;
            end
          end
          if (pick_ic) begin
            addr_d  = bus.IC_addr;
            mem_a_d = bus.IC_addr;
            nm1_d   = 2'd3;
            op_d    = OP_LW;
            state_d = READ;
          end
        end
        READ: begin
          if (jp_wrong) begin
            state_d  = IDLE;
            mem_wr_d = 1'b0;
          end else begin
            if (v_q) begin
              buf_d = asm_w;
              if (rcv_q == nm1_q) begin
                state_d = DONE;
                if (last_dc_q) begin
                  dc_done_d = 1'b1;
                  dc_data_d = ext_w;
                end else begin
                  ic_done_d = 1'b1;
                  ic_data_d = asm_w;
                end
              end else begin
                rcv_d = rcv_q + 2'd1;
              end
            end
            if (k_q != nm1_q) begin
              k_d     = k_nx;
              mem_a_d = addr_q + ADDR_W'(k_nx);
            end
            v_d = 1'b1;
          end
        end
        WRITE: begin
          if (!io_block) begin
            if (k_q == nm1_q) begin
              state_d   = DONE;
              mem_wr_d  = 1'b0;
              dc_done_d = 1'b1;
            end else begin
              k_d        = k_nx;
              mem_a_d    = addr_q + ADDR_W'(k_nx);
              mem_dout_d = st_val_q[{k_nx, 3'b000} +: 8];
            end
          end
        end
      endcase
    end else if (state_q == READ) begin
      // The byte in flight is lost; re-present it.
      k_d     = rcv_q;
      mem_a_d = addr_q + ADDR_W'(rcv_q);
      v_d     = 1'b0;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      last_dc_q  <= 1'b0;
      addr_q     <= '0;
      nm1_q      <= 2'd0;
      op_q       <= 6'd0;
      st_val_q   <= 32'd0;
      k_q        <= 2'd0;
      rcv_q      <= 2'd0;
      v_q        <= 1'b0;
      buf_q      <= 32'd0;
      mem_a_q    <= '0;
      mem_dout_q <= 8'd0;
      mem_wr_q   <= 1'b0;
      ic_done_q  <= 1'b0;
      dc_done_q  <= 1'b0;
      ic_data_q  <= 32'd0;
      dc_data_q  <= 32'd0;
    end else begin
      state_q    <= state_d;
      last_dc_q  <= last_dc_d;
      addr_q     <= addr_d;
      nm1_q      <= nm1_d;
      op_q       <= op_d;
      st_val_q   <= st_val_d;
      k_q        <= k_d;
      rcv_q      <= rcv_d;
      v_q        <= v_d;
      buf_q      <= buf_d;
      mem_a_q    <= mem_a_d;
      mem_dout_q <= mem_dout_d;
      mem_wr_q   <= mem_wr_d;
      ic_done_q  <= ic_done_d;
      dc_done_q  <= dc_done_d;
      ic_data_q  <= ic_data_d;
      dc_data_q  <= dc_data_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scoreboard bench for mem_arbiter with a byte RAM model.
// IO back-pressure expectations follow IO_BUFFER_FULL_EN.
module tb_mem_arbiter;

  localparam logic [5:0] LB  = 6'd1;
  localparam logic [5:0] LH  = 6'd2;
  localparam logic [5:0] LW  = 6'd3;
  localparam logic [5:0] LBU = 6'd4;
  localparam logic [5:0] LHU = 6'd5;
  localparam logic [5:0] SB  = 6'd6;
  localparam logic [5:0] SH  = 6'd7;
  localparam logic [5:0] SW  = 6'd8;

  typedef struct {
    logic        dc;
    logic        chk;
    logic [31:0] data;
  } done_t;

  typedef struct {
    logic [31:0] a;
    logic [7:0]  d;
  } wr_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic rdy = 1'b1;
  logic io_full = 1'b0;
  logic jp = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  done_t dq[$];
  wr_t   wq[$];
  done_t md;
  wr_t   mw;

  logic [7:0]  ram [0:262143];
  logic [31:0] a_log [1:40];
  logic        wr_log [1:40];
  logic [7:0]  do_log [1:40];

  mem_arbiter_if bus ();

  mem_arbiter dut (
    .clk            (clk),
    .rst            (rst),
    .rdy            (rdy),
    .io_buffer_full (io_full),
    .jp_wrong       (jp),
    .bus            (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    bus.mem_din <= ram[bus.mem_a[17:0]];
    if (bus.mem_wr)
      ram[bus.mem_a[17:0]] <= bus.mem_dout;
  end

  always @(negedge clk) begin
    #2;
    if (bus.mem_wr === 1'b1) begin
      n_tests++;
      if (wq.size() == 0) begin
        n_fail++;
        $display("FAIL wr_unexp a=%h d=%h want none",
                 bus.mem_a, bus.mem_dout);
      end else begin
        mw = wq.pop_front();
        if (bus.mem_a !== mw.a || bus.mem_dout !== mw.d) begin
          n_fail++;
          $display("FAIL wr_data got %h/%h want %h/%h",
                   bus.mem_a, bus.mem_dout, mw.a, mw.d);
        end
      end
    end
    if (bus.IC_done === 1'b1 || bus.DC_done === 1'b1) begin
      n_tests++;
      if (dq.size() == 0) begin
        n_fail++;
        $display("FAIL done_unexp ic=%b dc=%b want none",
                 bus.IC_done, bus.DC_done);
      end else begin
        md = dq.pop_front();
        if (bus.DC_done !== md.dc) begin
          n_fail++;
          $display("FAIL done_who got dc=%b want dc=%b",
                   bus.DC_done, md.dc);
        end else if (md.chk && md.dc
                     && bus.DC_data !== md.data) begin
          n_fail++;
          $display("FAIL dc_data got %h want %h",
                   bus.DC_data, md.data);
        end else if (md.chk && !md.dc
                     && bus.IC_data !== md.data) begin
          n_fail++;
          $display("FAIL ic_data got %h want %h",
                   bus.IC_data, md.data);
        end
      end
    end
  end

  task automatic poke(input int a, input logic [7:0] b);
    ram[a] <= b;
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    rdy = 1'b1;
    jp = 1'b0;
    io_full = 1'b0;
    bus.IC_sgn = 1'b0;
    bus.DC_sgn = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic run_req(input bit dc, input logic [31:0] addr,
                         input logic [5:0] op,
                         input logic [31:0] val, output int dcyc);
    if (dc) begin
      bus.DC_sgn = 1'b1;
      bus.DC_addr = addr;
      bus.DC_opcode = op;
      bus.DC_val = val;
    end else begin
      bus.IC_sgn = 1'b1;
      bus.IC_addr = addr;
    end
    dcyc = 0;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      a_log[c] = bus.mem_a;
      wr_log[c] = bus.mem_wr;
      do_log[c] = bus.mem_dout;
      if (dc ? bus.DC_done : bus.IC_done) begin
        dcyc = c;
        break;
      end
    end
    bus.DC_sgn = 1'b0;
    bus.IC_sgn = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus.DC_sgn = 1'b1;
    bus.DC_opcode = SW;
    bus.DC_addr = 32'h44;
    repeat (2) @(negedge clk);
    n_tests++;
    if ({bus.mem_wr, bus.IC_done, bus.DC_done} !== 3'b000) begin
      n_fail++;
      $display("FAIL rst_flags got %b want 000",
               {bus.mem_wr, bus.IC_done, bus.DC_done});
    end
    n_tests++;
    if (bus.mem_a !== 32'h0) begin
      n_fail++;
      $display("FAIL rst_mem_a got %h want 0", bus.mem_a);
    end
    n_tests++;
    if ({bus.mem_dout, bus.IC_data, bus.DC_data} !== 72'h0) begin
      n_fail++;
      $display("FAIL rst_data got %h/%h/%h want 0",
               bus.mem_dout, bus.IC_data, bus.DC_data);
    end
    bus.DC_sgn = 1'b0;
    apply_reset();
  endtask

  task automatic test_ic_fetch();
    int d;
    dq.push_back('{1'b0, 1'b1, 32'h44332211});
    run_req(1'b0, 32'h100, LW, 32'h0, d);
    n_tests++;
    if (d !== 6) begin
      n_fail++;
      $display("FAIL ic_done_cyc got %0d want 6", d);
    end
    for (int c = 1; c <= 4; c++) begin
      n_tests++;
      if (a_log[c] !== 32'h100 + 32'(c - 1)) begin
        n_fail++;
        $display("FAIL ic_mem_a c%0d got %h want %h",
                 c, a_log[c], 32'h100 + 32'(c - 1));
      end
    end
  endtask

  task automatic test_dc_load();
    int d;
    dq.push_back('{1'b1, 1'b1, 32'hFFFFFF80});
    run_req(1'b1, 32'h20, LB, 32'h0, d);
    n_tests++;
    if (d !== 3 || a_log[1] !== 32'h20) begin
      n_fail++;
      $display("FAIL lb_timing got %0d/%h want 3/20", d, a_log[1]);
    end
    dq.push_back('{1'b1, 1'b1, 32'h00000080});
    run_req(1'b1, 32'h20, LBU, 32'h0, d);
    n_tests++;
    if (d !== 3) begin
      n_fail++;
      $display("FAIL lbu_cyc got %0d want 3", d);
    end
    dq.push_back('{1'b1, 1'b1, 32'hFFFF9234});
    run_req(1'b1, 32'h60, LH, 32'h0, d);
    n_tests++;
    if (d !== 4) begin
      n_fail++;
      $display("FAIL lh_cyc got %0d want 4", d);
    end
    dq.push_back('{1'b1, 1'b1, 32'h00009234});
    run_req(1'b1, 32'h60, LHU, 32'h0, d);
    dq.push_back('{1'b1, 1'b1, 32'h84030201});
    run_req(1'b1, 32'h200, LW, 32'h0, d);
    n_tests++;
    if (d !== 6) begin
      n_fail++;
      $display("FAIL lw_cyc got %0d want 6", d);
    end
  endtask

  task automatic test_store();
    int d;
    logic [31:0] w;
    logic [31:0] v = 32'hDEADBEEF;
    for (int i = 0; i < 4; i++)
      wq.push_back('{32'h40 + 32'(i), v[8*i +: 8]});
    dq.push_back('{1'b1, 1'b0, 32'h0});
    run_req(1'b1, 32'h40, SW, v, d);
    n_tests++;
    if (d !== 5) begin
      n_fail++;
      $display("FAIL sw_cyc got %0d want 5", d);
    end
    for (int c = 1; c <= 4; c++) begin
      n_tests++;
      if (wr_log[c] !== 1'b1 || do_log[c] !== v[8*(c-1) +: 8]) begin
        n_fail++;
        $display("FAIL sw_byte c%0d got %b/%h want 1/%h",
                 c, wr_log[c], do_log[c], v[8*(c-1) +: 8]);
      end
    end
    n_tests++;
    if (wr_log[5] !== 1'b0) begin
      n_fail++;
      $display("FAIL sw_wr_done got %b want 0", wr_log[5]);
    end
    w = {ram[32'h43], ram[32'h42], ram[32'h41], ram[32'h40]};
    n_tests++;
    if (w !== v) begin
      n_fail++;
      $display("FAIL sw_ram got %h want %h", w, v);
    end
    wq.push_back('{32'h48, 8'h77});
    dq.push_back('{1'b1, 1'b0, 32'h0});
    run_req(1'b1, 32'h48, SB, 32'h12345677, d);
    n_tests++;
    if (d !== 2 || ram[32'h48] !== 8'h77) begin
      n_fail++;
      $display("FAIL sb got %0d/%h want 2/77", d, ram[32'h48]);
    end
  endtask

  task automatic test_round_robin();
    int cyc [4];
    logic who [4];
    int nd = 0;
    apply_reset();
    dq.push_back('{1'b1, 1'b1, 32'h84030201});
    dq.push_back('{1'b0, 1'b1, 32'h44332211});
    dq.push_back('{1'b1, 1'b1, 32'h84030201});
    dq.push_back('{1'b0, 1'b1, 32'h44332211});
    bus.DC_addr = 32'h200;
    bus.DC_opcode = LW;
    bus.IC_addr = 32'h100;
    bus.DC_sgn = 1'b1;
    bus.IC_sgn = 1'b1;
    for (int c = 1; c <= 40 && nd < 4; c++) begin
      @(negedge clk);
      if (bus.DC_done || bus.IC_done) begin
        who[nd] = bus.DC_done;
        cyc[nd] = c;
        nd++;
      end
    end
    bus.DC_sgn = 1'b0;
    bus.IC_sgn = 1'b0;
    repeat (2) @(negedge clk);
    n_tests++;
    if (nd !== 4) begin
      n_fail++;
      $display("FAIL rr_count got %0d want 4", nd);
    end
    for (int i = 0; i < nd; i++) begin
      n_tests++;
      if (who[i] !== ((i % 2) == 0) || cyc[i] !== 6 * (i + 1)) begin
        n_fail++;
        $display("FAIL rr_grant%0d got dc=%b c%0d want dc=%b c%0d",
                 i, who[i], cyc[i], (i % 2) == 0, 6 * (i + 1));
      end
    end
  endtask

  task automatic test_jp_wrong();
    int cnt = 0;
    int d = 0;
    logic [31:0] a4 = 32'h0;
    logic w4 = 1'b1;
    bus.IC_addr = 32'h100;
    bus.IC_sgn = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (bus.IC_done) cnt++;
      if (c == 3) begin
        jp = 1'b1;
        bus.IC_sgn = 1'b0;
      end
      if (c == 4) begin
        jp = 1'b0;
        a4 = bus.mem_a;
        w4 = bus.mem_wr;
      end
    end
    n_tests++;
    if (cnt !== 0 || a4 !== 32'h102 || w4 !== 1'b0) begin
      n_fail++;
      $display("FAIL jp_ic got %0d/%h/%b want 0/102/0", cnt, a4, w4);
    end
    wq.push_back('{32'h50, 8'hCD});
    wq.push_back('{32'h51, 8'hAB});
    dq.push_back('{1'b1, 1'b0, 32'h0});
    bus.DC_addr = 32'h50;
    bus.DC_opcode = SH;
    bus.DC_val = 32'h1234ABCD;
    bus.DC_sgn = 1'b1;
    for (int c = 1; c <= 10 && d == 0; c++) begin
      @(negedge clk);
      if (c == 1) jp = 1'b1;
      if (c == 2) jp = 1'b0;
      if (bus.DC_done) d = c;
    end
    bus.DC_sgn = 1'b0;
    @(negedge clk);
    n_tests++;
    if (d !== 3 || {ram[32'h51], ram[32'h50]} !== 16'hABCD) begin
      n_fail++;
      $display("FAIL jp_sh got %0d/%h want 3/abcd",
               d, {ram[32'h51], ram[32'h50]});
    end
    d = 0;
    dq.push_back('{1'b1, 1'b1, 32'hFFFFFF80});
    bus.DC_addr = 32'h20;
    bus.DC_opcode = LB;
    bus.DC_sgn = 1'b1;
    jp = 1'b1;
    for (int c = 1; c <= 10 && d == 0; c++) begin
      @(negedge clk);
      jp = 1'b0;
      if (bus.DC_done) d = c;
    end
    bus.DC_sgn = 1'b0;
    @(negedge clk);
    n_tests++;
    if (d !== 4) begin
      n_fail++;
      $display("FAIL jp_idle_block got %0d want 4", d);
    end
    cnt = 0;
    bus.DC_sgn = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (bus.DC_done) cnt++;
      if (c == 2) begin
        jp = 1'b1;
        bus.DC_sgn = 1'b0;
      end
      if (c == 3) jp = 1'b0;
    end
    n_tests++;
    if (cnt !== 0) begin
      n_fail++;
      $display("FAIL jp_last_capture got %0d want 0", cnt);
    end
  endtask

  task automatic test_stall();
    int d = 0;
    logic [31:0] w;
    for (int i = 0; i < 4; i++)
      wq.push_back('{32'h70 + 32'(i), 8'(4 - i)});
    dq.push_back('{1'b1, 1'b0, 32'h0});
    bus.DC_addr = 32'h70;
    bus.DC_opcode = SW;
    bus.DC_val = 32'h01020304;
    bus.DC_sgn = 1'b1;
    for (int c = 1; c <= 20 && d == 0; c++) begin
      @(negedge clk);
      if (c == 2) rdy = 1'b0;
      if (c == 3) rdy = 1'b1;
      if (bus.DC_done) d = c;
    end
    bus.DC_sgn = 1'b0;
    @(negedge clk);
    w = {ram[32'h73], ram[32'h72], ram[32'h71], ram[32'h70]};
    n_tests++;
    if (d !== 6 || w !== 32'h01020304) begin
      n_fail++;
      $display("FAIL stall_sw got %0d/%h want 6/01020304", d, w);
    end
    d = 0;
    dq.push_back('{1'b1, 1'b1, 32'h84030201});
    bus.DC_addr = 32'h200;
    bus.DC_opcode = LW;
    bus.DC_sgn = 1'b1;
    for (int c = 1; c <= 20 && d == 0; c++) begin
      @(negedge clk);
      if (c == 3) rdy = 1'b0;
      if (c == 4) rdy = 1'b1;
      if (bus.DC_done) d = c;
    end
    bus.DC_sgn = 1'b0;
    @(negedge clk);
    n_tests++;
    if (d !== 8) begin
      n_fail++;
      $display("FAIL stall_lw got %0d want 8", d);
    end
  endtask

  task automatic test_reset_mid();
    wq.push_back('{32'h90, 8'h44});
    wq.push_back('{32'h91, 8'h33});
    bus.DC_addr = 32'h90;
    bus.DC_opcode = SW;
    bus.DC_val = 32'h11223344;
    bus.DC_sgn = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    bus.DC_sgn = 1'b0;
    @(negedge clk);
    n_tests++;
    if ({bus.mem_wr, bus.DC_done} !== 2'b00 || bus.mem_a !== 32'h0) begin
      n_fail++;
      $display("FAIL rst_mid got %b/%b/%h want 0/0/0",
               bus.mem_wr, bus.DC_done, bus.mem_a);
    end
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_tests++;
    if ({ram[32'h93], ram[32'h92], ram[32'h91]} !== 24'h000033) begin
      n_fail++;
      $display("FAIL rst_mid_ram got %h want 000033",
               {ram[32'h93], ram[32'h92], ram[32'h91]});
    end
  endtask

  task automatic test_io();
    int d = 0;
    int early = 0;
    int want;
    wq.push_back('{32'h30000, 8'hA5});
    dq.push_back('{1'b1, 1'b0, 32'h0});
    io_full = 1'b1;
    bus.DC_addr = 32'h30000;
    bus.DC_opcode = SB;
    bus.DC_val = 32'h000000A5;
    bus.DC_sgn = 1'b1;
    for (int c = 1; c <= 20 && d == 0; c++) begin
      @(negedge clk);
      if (c <= 4 && bus.mem_wr) early++;
      if (c == 5) io_full = 1'b0;
      if (bus.DC_done) d = c;
    end
    bus.DC_sgn = 1'b0;
    io_full = 1'b0;
    @(negedge clk);
`ifdef IO_BUFFER_FULL_EN
    want = 6;
    n_tests++;
    if (early !== 0) begin
      n_fail++;
      $display("FAIL io_blocked got %0d writes want 0", early);
    end
`else
    want = 2;
`endif
    n_tests++;
    if (d !== want || ram[32'h30000] !== 8'hA5) begin
      n_fail++;
      $display("FAIL io_sb got %0d/%h want %0d/a5",
               d, ram[32'h30000], want);
    end
  endtask

  initial begin
    bus.IC_sgn = 1'b0;
    bus.IC_addr = 32'h0;
    bus.DC_sgn = 1'b0;
    bus.DC_addr = 32'h0;
    bus.DC_val = 32'h0;
    bus.DC_opcode = 6'd0;
    for (int i = 0; i < 1024; i++) ram[i] <= 8'h00;
    poke(32'h30000, 8'h00);
    poke(32'h100, 8'h11);
    poke(32'h101, 8'h22);
    poke(32'h102, 8'h33);
    poke(32'h103, 8'h44);
    poke(32'h20, 8'h80);
    poke(32'h60, 8'h34);
    poke(32'h61, 8'h92);
    poke(32'h200, 8'h01);
    poke(32'h201, 8'h02);
    poke(32'h202, 8'h03);
    poke(32'h203, 8'h84);
    test_reset();
    test_ic_fetch();
    test_dc_load();
    test_store();
    test_round_robin();
    test_jp_wrong();
    test_stall();
    test_reset_mid();
    test_io();
    repeat (3) @(negedge clk);
    n_tests++;
    if (wq.size() != 0 || dq.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_left got %0d/%0d want 0/0",
               wq.size(), dq.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Owns the single byte-wide RAM/IO port. Shares it between the ICache fetch path and the DCache/LSB load-store path.
- Converts word, half and byte requests into sequential byte transactions, then returns assembled or sign-extended data with a one-cycle done pulse.
- Sits between the IF/ICache, the LSB/DCache and the top-level memory pins. Honours jp_wrong flushes and the global rdy stall.

Parameters:
- ADDR_W, 32, address width of all request and memory address ports.
- IO_HI, 2'b11, value of addr[17:16] that selects the IO region.

Ports:
- clk  in  1  clock, all state updates on posedge
- rst  in  1  reset, synchronous, active-low
- rdy  in  1  global ready; low = stall
- mem_din  in  8  RAM read byte, valid one cycle after its address is presented
- mem_dout  out  8  RAM write byte
- mem_a  out  32  RAM byte address
- mem_wr  out  1  1 = write, 0 = read
- io_buffer_full  in  1  IO write buffer full
- IC_sgn  in  1  fetch request, held until IC_done
- IC_addr  in  32  fetch word address
- IC_done  out  1  one-cycle pulse, IC_data valid
- IC_data  out  32  fetched word
- DC_sgn  in  1  load/store request, held until DC_done
- DC_addr  in  32  byte address
- DC_val  in  32  store data; bytes taken from the LSB end
- DC_opcode  in  6  one of `LB `LH `LW `LBU `LHU `SB `SH `SW (defines.v)
- DC_done  out  1  one-cycle pulse, load data valid or store finished
- DC_data  out  32  load result, sign- or zero-extended
- jp_wrong  in  1  misprediction flush

Behaviour:
- Reset values (rst=0 at posedge):
  - state=IDLE.
  - mem_wr=0, mem_a=0, mem_dout=0.
  - IC_done=0, DC_done=0, IC_data=0, DC_data=0.
  - Priority pointer favours DC.
- States: IDLE, READ, WRITE, DONE.
- IDLE, acceptance edge E0:
  - If one or more requesters are eligible, grant one.
  - When both are eligible, grant the one not served last (round-robin). The first grant after reset goes to DC.
  - On grant, latch address, length n (1/2/4), direction and store data. Set byte index k=0.
- Registered outputs. In cycle c (the cycle after edge Ec):
  - mem_a = addr+(c-1) for c=1..n.
  - mem_wr=1 only in WRITE.
- READ:
  - The byte for index k is captured from mem_din at edge E(k+2).
  - After capturing byte n-1 at edge E(n+1), move to DONE and register data + done.
  - Done is high in cycle n+2: LW done in cycle 6, LB in cycle 3.
- WRITE:
  - mem_dout = DC_val byte k in cycle k+1.
  - At edge En move to DONE with done high in cycle n+1 and mem_wr=0.
  - SW done in cycle 5.
- IC always uses n=4 read. Byte 0 goes to [7:0] (little-endian).
- Load extension:
  - LB/LH sign-extend from bit 7/15.
  - LBU/LHU zero-extend.
  - LW takes the word as is.
- DONE:
  - Lasts exactly one cycle, then IDLE.
  - The requester just served is ineligible at the edge ending its DONE cycle, because its sgn is still high.
  - The other requester may be granted at that edge.
- Idle outputs: mem_wr=0. mem_a holds its last value.
- jp_wrong=1 at an edge while serving an IC read or a DC load:
  - Abort to IDLE.
  - No done pulse.
  - mem_wr=0 the next cycle.
- jp_wrong does not abort DC stores (they are committed). jp_wrong in IDLE blocks acceptance at that edge.
- Simultaneous jp_wrong and final-capture edge: the abort wins and no done is issued.
- rdy=0:
  - All registers hold. mem_wr is forced to 0 combinationally.
  - When rdy returns, the current byte index is re-presented. Read capture for it occurs one edge later.
- rst low mid-transaction: immediate return to reset values. A partial store is not completed.

Optional Feature:
- Macro: IO_BUFFER_FULL_EN.
- With the macro defined: a store byte with addr[17:16]==IO_HI is not presented while io_buffer_full=1. mem_wr=0, index holds, and the byte resumes the cycle after io_buffer_full falls.
- Without the macro: io_buffer_full is ignored.

Test Plan:
- IC_sgn=1, IC_addr=0x100, RAM[0x100..0x103]=11 22 33 44 -> IC_done in cycle 6, IC_data=0x44332211, mem_a 0x100..0x103 in cycles 1..4.
- DC LB addr 0x20, RAM=0x80 -> DC_done cycle 3, DC_data=0xFFFFFF80. With LBU -> 0x00000080.
- DC SW addr 0x40, DC_val=0xDEADBEEF -> mem_wr=1 cycles 1..4, mem_dout EF BE AD DE, DC_done cycle 5.
- IC_sgn and DC_sgn both held from reset -> grants alternate DC, IC, DC, IC. Neither is granted twice consecutively.
- IC read in flight, jp_wrong pulse in cycle 3 -> no IC_done, IDLE next cycle. Same pulse during an SH completes the store with DC_done.
- With IO_BUFFER_FULL_EN: SB to 0x30000 while io_buffer_full=1 for 5 cycles -> mem_wr stays 0 until it falls, then one write of the byte and DC_done.
